// File: rtl/sender_scheduler.sv
// rtl/sender_scheduler.sv - three-way arbiter feeding the 40-bit serial frame sender
//
// Grants one requester per frame slot and drives the sender's load strobe.
// Each slot is one IDLE (grant) cycle, then PULSE_CYCLES of snd_valid, then
// FRAME_CYCLES of guard time while the sender shifts the frame out.
//
// Ports:
//   clk         in   rising-edge clock shared with the sender
//   rst_n       in   synchronous reset, active low
//   req_valid   in   [2:0] requester has a word
//   req_data    in   [3*DATA_W-1:0] requester i at bits [i*DATA_W +: DATA_W]
//   req_ready   out  [2:0] one-hot acceptance strobe (IDLE only)
//   snd_data    out  [DATA_W-1:0] word loaded into the sender
//   snd_valid   out  sender load strobe
//   grant_id    out  [1:0] owner of the current/last slot
//   busy        out  high whenever not IDLE
//   frame_done  out  one-cycle pulse on WAIT->IDLE
module sender_scheduler #(
  parameter int DATA_W       = 40,
  parameter int PULSE_CYCLES = 2,
  parameter int FRAME_CYCLES = 44,
  parameter bit PRIO0        = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            req_valid,
  input  logic [3*DATA_W-1:0]   req_data,
  output logic [2:0]            req_ready,
  output logic [DATA_W-1:0]     snd_data,
  output logic                  snd_valid,
  output logic [1:0]            grant_id,
  output logic                  busy,
  output logic                  frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES);
  localparam logic [7:0] FRAME_LOAD = 8'(FRAME_CYCLES);

  state_t            state;
  logic [7:0]        cnt;
  logic [1:0]        rr_ptr;
  logic [1:0]        winner;
  logic [1:0]        ptr_plus1;
  logic [1:0]        ptr_plus2;
  logic [1:0]        next_ptr;
  logic [3:0]        valid_pad;
  logic [DATA_W-1:0] win_data;

  // Round-robin scan starting at rr_ptr; requester 0 may pre-empt the scan.
  // valid_pad keeps the rr_ptr index in range even for the unused value 3.
  always_comb begin
    valid_pad = {1'b0, req_valid};
    ptr_plus1 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
    ptr_plus2 = (ptr_plus1 == 2'd2) ? 2'd0 : ptr_plus1 + 2'd1;
    winner    = ptr_plus2;
    if (PRIO0 && req_valid[0]) begin
      winner = 2'd0;
    end else if (valid_pad[rr_ptr]) begin
      winner = rr_ptr;
    end else if (valid_pad[ptr_plus1]) begin
      winner = ptr_plus1;
    end
    next_ptr = (winner == 2'd2) ? 2'd0 : winner + 2'd1;
  end

  always_comb begin
    case (winner)
      2'd0:    win_data = req_data[0 +: DATA_W];
      2'd1:    win_data = req_data[DATA_W +: DATA_W];
      default: win_data = req_data[2*DATA_W +: DATA_W];
    endcase
  end

  always_comb begin
    req_ready = 3'b000;
    if (state == IDLE && |req_valid) begin
      req_ready = 3'b001 << winner;
    end
    busy = (state != IDLE);
  end

  // Reset lands in WAIT so a frame the sender may already be shifting
  // gets a full guard interval before the first grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= WAIT;
      cnt        <= FRAME_LOAD;
      rr_ptr     <= 2'd0;
      snd_valid  <= 1'b0;
      snd_data   <= '0;
      grant_id   <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            snd_data  <= win_data;
            grant_id  <= winner;
            rr_ptr    <= next_ptr;
            cnt       <= PULSE_LOAD;
            snd_valid <= 1'b1;
            state     <= PULSE;
          end
        end
        PULSE: begin
          if (cnt == 8'd1) begin
            snd_valid <= 1'b0;
            cnt       <= FRAME_LOAD;
            state     <= WAIT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        WAIT: begin
          if (cnt == 8'd1) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          snd_valid <= 1'b0;
          cnt       <= FRAME_LOAD;
          state     <= WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sender_scheduler.sv
// tb/tb_sender_scheduler.sv - self-checking bench for sender_scheduler
module tb_sender_scheduler;
  localparam int DW = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_a = 1'b0, rst_b = 1'b0;
  logic [2:0]      v_a = 3'b000, v_b = 3'b000;
  logic [3*DW-1:0] d_a = '0, d_b = '0;
  logic [2:0]      ready_a, ready_b;
  logic [DW-1:0]   sdata_a, sdata_b;
  logic            svalid_a, svalid_b;
  logic [1:0]      gid_a, gid_b;
  logic            busy_a, busy_b, fd_a, fd_b;

  sender_scheduler #(.DATA_W(DW), .PULSE_CYCLES(2), .FRAME_CYCLES(44), .PRIO0(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_a), .req_valid(v_a), .req_data(d_a), .req_ready(ready_a),
    .snd_data(sdata_a), .snd_valid(svalid_a), .grant_id(gid_a), .busy(busy_a), .frame_done(fd_a));

  sender_scheduler #(.DATA_W(DW), .PULSE_CYCLES(2), .FRAME_CYCLES(44), .PRIO0(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_b), .req_valid(v_b), .req_data(d_b), .req_ready(ready_b),
    .snd_data(sdata_b), .snd_valid(svalid_b), .grant_id(gid_b), .busy(busy_b), .frame_done(fd_b));

  int errors = 0;
  int checks = 0;
  int multihot = 0, overlap = 0, frame_err = 0, frames_ok = 0, accepted_b = 0;
  int m_ptr_a = 0, m_ptr_b = 0;
  logic [2:0] acc_mask_b = 3'b000;
  logic [DW-1:0] sb_q[$];

  function automatic logic [DW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] word_of(logic [3*DW-1:0] d, int i);
    return d[i*DW +: DW];
  endfunction

  // Arbitration rule: requester 0 first when prioritised, else first valid
  // requester going round from the pointer.
  function automatic int model_pick(logic [2:0] v, int ptr, bit prio);
    if (v == 3'b000) return -1;
    if (prio && v[0]) return 0;
    for (int k = 0; k < 3; k++) begin
      if (v[(ptr + k) % 3]) return (ptr + k) % 3;
    end
    return -1;
  endfunction

  function automatic int oh_index(logic [2:0] m);
    return m[0] ? 0 : (m[1] ? 1 : 2);
  endfunction

  // Acceptance monitor: records what each DUT actually takes on a clock edge.
  always @(posedge clk) begin
    if ($countones(ready_a) > 1 || $countones(ready_b) > 1) multihot++;
    acc_mask_b = rst_b ? ready_b : 3'b000;
    if (acc_mask_b != 3'b000) begin
      sb_q.push_back(word_of(d_b, oh_index(acc_mask_b)));
      accepted_b++;
    end
  end

  // Behavioural serial sender on dut_b: latches on snd_valid rising, then
  // shifts a 1 start bit followed by the word LSB first.
  logic [DW:0] shreg = '0;
  int          bits_left = 0;
  logic        sv_prev = 1'b0;
  logic        sout = 1'b0;
  always @(posedge clk) begin
    if (svalid_b && !sv_prev) begin
      if (bits_left != 0) overlap++;
      shreg     = {sdata_b, 1'b1};
      bits_left = DW + 1;
    end else if (bits_left > 0) begin
      shreg     = shreg >> 1;
      bits_left = bits_left - 1;
    end
    sv_prev = svalid_b;
    sout    = (bits_left > 0) ? shreg[0] : 1'b0;
  end

  // Frame decoder on sout.
  logic          in_frame = 1'b0;
  int            nb = 0;
  logic [DW-1:0] rx_word = '0;
  always @(negedge clk) begin
    if (!in_frame) begin
      if (sout) begin
        in_frame = 1'b1;
        nb = 0;
      end
    end else begin
      rx_word[nb] = sout;
      nb++;
      if (nb == DW) begin
        in_frame = 1'b0;
        if (sb_q.size() == 0) frame_err++;
        else if (sb_q.pop_front() !== rx_word) frame_err++;
        else frames_ok++;
      end
    end
  end

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (svalid_a !== 1'b0) begin errors++; $display("FAIL reset_snd_valid: got %b expected 0", svalid_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy_a); end
    checks++; if (gid_a !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", gid_a); end
    checks++; if (fd_a !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", fd_a); end
    checks++; if (sdata_a !== '0) begin errors++; $display("FAIL reset_snd_data: got %h expected 0", sdata_a); end
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL reset_busy_b: got %b expected 1", busy_b); end
    rst_a = 1'b1; rst_b = 1'b1;
    m_ptr_a = 0; m_ptr_b = 0;
  endtask

  task automatic test_single();
    logic [DW-1:0] w;
    int k;
    int hi;
    time t_rise;
    time t_fd;
    w = 40'hD99999991;
    d_a = {rand_word(), w, rand_word()};
    v_a = 3'b010;
    k = 0;
    while (busy_a && k < 200) begin @(negedge clk); k++; end
    checks++; if (k != 44) begin errors++; $display("FAIL single_guard: got %0d cycles expected 44", k); end
    checks++; if (ready_a !== 3'b010) begin errors++; $display("FAIL single_ready: got %b expected 010", ready_a); end
    @(negedge clk);
    t_rise = $time;
    m_ptr_a = (model_pick(3'b010, m_ptr_a, 1'b1) + 1) % 3;
    checks++; if (ready_a !== 3'b000) begin errors++; $display("FAIL single_ready_once: got %b expected 000", ready_a); end
    v_a = 3'b000;
    checks++; if (svalid_a !== 1'b1) begin errors++; $display("FAIL single_snd_valid: got %b expected 1", svalid_a); end
    checks++; if (sdata_a !== w) begin errors++; $display("FAIL single_snd_data: got %h expected %h", sdata_a, w); end
    checks++; if (gid_a !== 2'd1) begin errors++; $display("FAIL single_grant_id: got %0d expected 1", gid_a); end
    hi = 1;
    @(negedge clk);
    while (svalid_a && hi < 20) begin hi++; @(negedge clk); end
    checks++; if (hi != 2) begin errors++; $display("FAIL single_pulse_width: got %0d expected 2", hi); end
    k = 0;
    while (!fd_a && k < 200) begin @(negedge clk); k++; end
    t_fd = $time;
    checks++; if ((t_fd - t_rise) / 10 != 46) begin errors++; $display("FAIL single_frame_done_delay: got %0d expected 46", (t_fd - t_rise) / 10); end
    @(negedge clk);
    checks++; if (fd_a !== 1'b0) begin errors++; $display("FAIL single_frame_done_width: got %b expected 0", fd_a); end
  endtask

  task automatic test_prio_order();
    logic [2:0]    pend;
    logic [2:0]    oh;
    logic [DW-1:0] words[3];
    int            expw;
    int            k;
    time           t_prev;
    time           t_now;
    pend = 3'b111;
    for (int i = 0; i < 3; i++) words[i] = rand_word();
    d_a = {words[2], words[1], words[0]};
    v_a = pend;
    t_prev = 0;
    for (int g = 0; g < 3; g++) begin
      expw = model_pick(pend, m_ptr_a, 1'b1);
      oh = 3'b001 << expw;
      k = 0;
      while (ready_a == 3'b000 && k < 300) begin @(negedge clk); k++; end
      t_now = $time;
      checks++; if (ready_a !== oh) begin errors++; $display("FAIL prio_ready_%0d: got %b expected %b", g, ready_a, oh); end
      if (g > 0) begin
        checks++; if ((t_now - t_prev) / 10 != 47) begin errors++; $display("FAIL prio_spacing_%0d: got %0d expected 47", g, (t_now - t_prev) / 10); end
      end
      t_prev = t_now;
      @(negedge clk);
      checks++; if (gid_a !== 2'(expw)) begin errors++; $display("FAIL prio_grant_%0d: got %0d expected %0d", g, gid_a, expw); end
      checks++; if (sdata_a !== words[expw]) begin errors++; $display("FAIL prio_data_%0d: got %h expected %h", g, sdata_a, words[expw]); end
      pend[expw] = 1'b0;
      v_a = pend;
      m_ptr_a = (expw + 1) % 3;
    end
  endtask

  task automatic test_rr();
    logic [DW-1:0] words[3];
    logic [2:0]    oh;
    int            expw;
    int            k;
    for (int i = 0; i < 3; i++) words[i] = rand_word();
    d_b = {words[2], words[1], words[0]};
    v_b = 3'b111;
    for (int g = 0; g < 6; g++) begin
      expw = model_pick(3'b111, m_ptr_b, 1'b0);
      oh = 3'b001 << expw;
      k = 0;
      @(negedge clk);
      while (acc_mask_b == 3'b000 && k < 300) begin @(negedge clk); k++; end
      checks++; if (acc_mask_b !== oh) begin errors++; $display("FAIL rr_accept_%0d: got %b expected %b", g, acc_mask_b, oh); end
      checks++; if (gid_b !== 2'(expw)) begin errors++; $display("FAIL rr_grant_%0d: got %0d expected %0d", g, gid_b, expw); end
      checks++; if (sdata_b !== words[expw]) begin errors++; $display("FAIL rr_data_%0d: got %h expected %h", g, sdata_b, words[expw]); end
      m_ptr_b = (expw + 1) % 3;
    end
    v_b = 3'b000;
    checks++; if (multihot != 0) begin errors++; $display("FAIL rr_multihot: got %0d expected 0", multihot); end
  endtask

  task automatic test_starve();
    logic [DW-1:0] words[3];
    logic [2:0]    pend;
    logic [2:0]    oh;
    int            expw;
    int            k;
    for (int i = 0; i < 3; i++) words[i] = rand_word();
    d_a = {words[2], words[1], words[0]};
    pend = 3'b101;
    v_a = pend;
    for (int g = 0; g < 5; g++) begin
      expw = model_pick(pend, m_ptr_a, 1'b1);
      oh = 3'b001 << expw;
      k = 0;
      while (ready_a == 3'b000 && k < 300) begin @(negedge clk); k++; end
      checks++; if (ready_a !== oh) begin errors++; $display("FAIL starve_ready_%0d: got %b expected %b", g, ready_a, oh); end
      @(negedge clk);
      checks++; if (gid_a !== 2'(expw)) begin errors++; $display("FAIL starve_grant_%0d: got %0d expected %0d", g, gid_a, expw); end
      m_ptr_a = (expw + 1) % 3;
      if (g == 3) pend = 3'b100;
      if (g == 4) pend = 3'b000;
      v_a = pend;
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [2:0] oh;
    int         expw;
    int         k;
    d_a = {rand_word(), rand_word(), rand_word()};
    v_a = 3'b010;
    k = 0;
    while (ready_a == 3'b000 && k < 300) begin @(negedge clk); k++; end
    checks++; if (ready_a !== 3'b010) begin errors++; $display("FAIL midrst_pre_ready: got %b expected 010", ready_a); end
    @(negedge clk);
    checks++; if (svalid_a !== 1'b1) begin errors++; $display("FAIL midrst_in_pulse: got %b expected 1", svalid_a); end
    rst_a = 1'b0;
    v_a = 3'b110;
    @(negedge clk);
    rst_a = 1'b1;
    m_ptr_a = 0;
    checks++; if (svalid_a !== 1'b0) begin errors++; $display("FAIL midrst_snd_valid: got %b expected 0", svalid_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b expected 1", busy_a); end
    checks++; if (gid_a !== 2'd0) begin errors++; $display("FAIL midrst_grant_id: got %0d expected 0", gid_a); end
    expw = model_pick(3'b110, m_ptr_a, 1'b1);
    oh = 3'b001 << expw;
    k = 0;
    while (ready_a == 3'b000 && k < 200) begin @(negedge clk); k++; end
    checks++; if (k != 44) begin errors++; $display("FAIL midrst_guard: got %0d cycles expected 44", k); end
    checks++; if (ready_a !== oh) begin errors++; $display("FAIL midrst_ptr_restart: got %b expected %b", ready_a, oh); end
    @(negedge clk);
    v_a = 3'b000;
    m_ptr_a = (expw + 1) % 3;
  endtask

  task automatic test_cosim();
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (acc_mask_b[i]) v_b[i] = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (!v_b[i] && $urandom_range(0, 7) == 0) begin
          d_b[i*DW +: DW] = rand_word();
          v_b[i] = 1'b1;
        end
      end
    end
    @(negedge clk);
    v_b = 3'b000;
    repeat (150) @(negedge clk);
    checks++; if (frame_err != 0) begin errors++; $display("FAIL cosim_frame_errors: got %0d expected 0", frame_err); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL cosim_overlap: got %0d expected 0", overlap); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL cosim_undelivered: got %0d expected 0", sb_q.size()); end
    checks++; if (frames_ok != accepted_b) begin errors++; $display("FAIL cosim_frame_count: got %0d expected %0d", frames_ok, accepted_b); end
    checks++; if (accepted_b < 12) begin errors++; $display("FAIL cosim_activity: got %0d expected >= 12", accepted_b); end
    checks++; if (multihot != 0) begin errors++; $display("FAIL cosim_multihot: got %0d expected 0", multihot); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prio_order();
    test_rr();
    test_starve();
    test_reset_mid_pulse();
    test_cosim();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
